pic_cmd_ctrl: RTL and testbench
===============================

// Module: pic_cmd_ctrl
// PURPOSE
//  Clocked, parametrised successor to the 8259-style read/write control logic.
//  Synchronises the async CPU bus (CS/WR/RD/A0/Data_in) and sequences ICW1..ICW4
//  with an init FSM that skips ICW3 (single mode) and ICW4 (IC4=0).
//  Holds OCW1..OCW3 and drives a registered read-back bus (IRR/ISR/IMR).
//  Sits between the CPU bus pins and the priority resolver / in-service logic.
// PARAMETERS
//  DATA_W       8   bus, command-register and IRR/ISR/IMR width (>=8; bits [7:0] decoded)
//  SYNC_STAGES  2   flop stages on CS, WR, RD and A0 (>=2)
// PORTS
//  clk       in   1       system clock; all logic on rising edge
//  rst_n     in   1       synchronous reset, active low
//  CS        in   1       chip select, active low, async
//  WR        in   1       write strobe, active low, async
//  RD        in   1       read strobe, active low, async
//  A0        in   1       register address bit
//  Data_in   in   DATA_W  write data
//  IRR       in   DATA_W  interrupt request register, from core
//  ISR       in   DATA_W  in-service register, from core
//  Data_out  out  DATA_W  registered read data
//  Data_oe   out  1       read-bus drive enable
//  ICW1..ICW4,OCW1..OCW3 out DATA_W  latched command words
//  init_done out  1       high in READY state
//  icw1_stb  out  1       1-cycle pulse on ICW1 commit
//  ocw2_stb  out  1       1-cycle pulse on OCW2 commit
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all ICW/OCW regs=0, Data_out=0, Data_oe=0,
//   strobes=0, init_done=0, read_sel=IRR, FSM=IDLE; synchronisers load 1 (idle).
//   Reset mid-sequence aborts the sequence; the next write must be ICW1.
//  Sampling: cs_s/wr_s/rd_s/a0_s = SYNC_STAGES-deep copies. While wr_s=0, cs_s=0,
//   rd_s=1, data_cap<=Data_in and a0_cap<=a0_s each cycle.
//  Commit: wr_s 0->1 while cs_s=0 and rd_s=1. Regs and strobes update on the
//   commit edge = SYNC_STAGES+1 clks after WR rises. Otherwise no commit:
//   CS high at the edge, or RD and WR both low (bus error, write dropped).
//  Decode (a0_cap, data_cap):
//   A0=0,D4=1 -> ICW1 in any state: ICW1<=data, OCW1<=0, ICW4<=0,
//     read_sel<=IRR, icw1_stb=1, FSM->WAIT_ICW2.
//   A0=0,D4=0,D3=0 -> OCW2 in READY only: OCW2<=data, ocw2_stb=1.
//   A0=0,D4=0,D3=1 -> OCW3 in READY only: OCW3<=data; if D1(RR)=1 then
//     read_sel<=D0(RIS) ? ISR : IRR; if RR=0, read_sel is kept.
//   A0=1: WAIT_ICW2->ICW2; WAIT_ICW3->ICW3; WAIT_ICW4->ICW4; READY->OCW1; IDLE->ignored.
//   OCW2/OCW3 writes outside READY are ignored.
//  FSM: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
//   After ICW2: ICW1[1]=0 -> WAIT_ICW3; else ICW1[0]=1 -> WAIT_ICW4; else READY.
//   After ICW3: ICW1[0]=1 -> WAIT_ICW4; else READY. After ICW4 -> READY.
//   ICW1 restarts from any state. init_done = (FSM==READY).
//  Read: when cs_s=0, rd_s=0, wr_s=1, then next clk Data_oe=1 and
//   Data_out = a0_s ? OCW1 : (read_sel==ISR ? ISR : IRR).
//   Data_out is refreshed every cycle while the read is active.
//   When the read ends, Data_oe=0 the next clk and Data_out holds its last value.
//   Reads never change state.
//  Width: bits above [7] of Data_in are stored but not decoded.
// TESTING
//  T1 reset: rst_n=0 for 2 clks -> all regs 0, init_done=0, Data_oe=0.
//  T2 full init: A0=0 D5; A0=1 E8, 0B, 00 -> ICW1=D5 ICW2=E8 ICW3=0B ICW4=00,
//     init_done=1. Each commit lands SYNC_STAGES+1 clks after WR rises.
//  T3 ops after T2: A0=1 1F -> OCW1=1F. A0=0 E0 -> OCW2=E0 with a 1-clk ocw2_stb.
//     A0=0 68 -> OCW3=68, read_sel unchanged.
//  T4 skips: A0=0 16 (SNGL=1, IC4=0), then A0=1 40 -> READY after ICW2, ICW4=00.
//     A next A0=1 write lands in OCW1.
//  T5 read-back: IRR=A5, ISR=3C. RD A0=0 -> A5. OCW3=0B, RD A0=0 -> 3C.
//     RD A0=1 -> OCW1. OCW3=08 (RR=0), RD A0=0 -> still 3C.
//  T6 corners: ICW1 issued in WAIT_ICW3 -> FSM=WAIT_ICW2, OCW1=0. WR with CS=1 -> no change.
//     WR and RD both low -> no commit. Reset in WAIT_ICW4 -> IDLE; an A0=1 write is then ignored.

Source files
------------

// File: rtl/pic_cmd_ctrl.sv
// 8259-style command/control block: synchronises the CPU bus, sequences
// ICW1..ICW4 through an init FSM and drives a registered read-back bus.
module pic_cmd_ctrl #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS,
    input  logic              WR,
    input  logic              RD,
    input  logic              A0,
    input  logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] IRR,
    input  logic [DATA_W-1:0] ISR,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    output logic [DATA_W-1:0] ICW1,
    output logic [DATA_W-1:0] ICW2,
    output logic [DATA_W-1:0] ICW3,
    output logic [DATA_W-1:0] ICW4,
    output logic [DATA_W-1:0] OCW1,
    output logic [DATA_W-1:0] OCW2,
    output logic [DATA_W-1:0] OCW3,
    output logic              init_done,
    output logic              icw1_stb,
    output logic              ocw2_stb
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ICW2,
        S_WAIT_ICW3,
        S_WAIT_ICW4,
        S_READY
    } state_e;

    state_e state_q;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] rd_sync_q;
    logic [SYNC_STAGES-1:0] a0_sync_q;

    logic cs_s;
    logic wr_s;
    logic rd_s;
    logic a0_s;

    logic [DATA_W-1:0] data_cap_q;
    logic              a0_cap_q;
    logic              wr_ok_q;
    logic              sel_isr_q;

    logic [DATA_W-1:0] icw1_q;
    logic [DATA_W-1:0] icw2_q;
    logic [DATA_W-1:0] icw3_q;
    logic [DATA_W-1:0] icw4_q;
    logic [DATA_W-1:0] ocw1_q;
    logic [DATA_W-1:0] ocw2_q;
    logic [DATA_W-1:0] ocw3_q;
    logic [DATA_W-1:0] dout_q;
    logic              doe_q;
    logic              done_q;
    logic              icw1_stb_q;
    logic              ocw2_stb_q;

    logic              capture;
    logic              commit;
    logic              rd_act;
    logic              is_icw1;
    logic              is_ocw2;
    logic              is_ocw3;
    logic [DATA_W-1:0] rd_data;

    assign cs_s = cs_sync_q[SYNC_STAGES-1];
    assign wr_s = wr_sync_q[SYNC_STAGES-1];
    assign rd_s = rd_sync_q[SYNC_STAGES-1];
    assign a0_s = a0_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync_q <= '1;
            wr_sync_q <= '1;
            rd_sync_q <= '1;
            a0_sync_q <= '1;
        end else begin
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], WR};
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], RD};
            a0_sync_q <= {a0_sync_q[SYNC_STAGES-2:0], A0};
        end
    end

    // wr_ok_q: the cycle just before WR's rising edge was a clean write cycle
    assign capture = ~wr_s & ~cs_s & rd_s;
    assign commit  = wr_ok_q & wr_s & ~cs_s & rd_s;
    assign rd_act  = ~cs_s & ~rd_s & wr_s;

    assign is_icw1 = ~a0_cap_q & data_cap_q[4];
    assign is_ocw2 = ~a0_cap_q & ~data_cap_q[4] & ~data_cap_q[3];
    assign is_ocw3 = ~a0_cap_q & ~data_cap_q[4] & data_cap_q[3];

    assign rd_data = a0_s ? ocw1_q : (sel_isr_q ? ISR : IRR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_cap_q <= '0;
            a0_cap_q   <= 1'b0;
            wr_ok_q    <= 1'b0;
            sel_isr_q  <= 1'b0;
            icw1_q     <= '0;
            icw2_q     <= '0;
            icw3_q     <= '0;
            icw4_q     <= '0;
            ocw1_q     <= '0;
            ocw2_q     <= '0;
            ocw3_q     <= '0;
            dout_q     <= '0;
            doe_q      <= 1'b0;
            done_q     <= 1'b0;
            icw1_stb_q <= 1'b0;
            ocw2_stb_q <= 1'b0;
        end else begin
            icw1_stb_q <= 1'b0;
            ocw2_stb_q <= 1'b0;
            wr_ok_q    <= capture;
            doe_q      <= rd_act;
            if (rd_act) begin
                dout_q <= rd_data;
            end
            if (capture) begin
                data_cap_q <= Data_in;
                a0_cap_q   <= a0_s;
            end
            if (commit) begin
                unique case (1'b1)
                    is_icw1: begin
                        icw1_q     <= data_cap_q;
                        ocw1_q     <= '0;
                        icw4_q     <= '0;
                        sel_isr_q  <= 1'b0;
                        icw1_stb_q <= 1'b1;
                        state_q    <= S_WAIT_ICW2;
                        done_q     <= 1'b0;
                    end
                    is_ocw2: begin
                        if (state_q == S_READY) begin
                            ocw2_q     <= data_cap_q;
                            ocw2_stb_q <= 1'b1;
                        end
                    end
                    is_ocw3: begin
                        if (state_q == S_READY) begin
                            ocw3_q <= data_cap_q;
                            if (data_cap_q[1]) begin
                                sel_isr_q <= data_cap_q[0];
                            end
                        end
                    end
                    a0_cap_q: begin
                        unique case (state_q)
                            S_WAIT_ICW2: begin
                                icw2_q <= data_cap_q;
                                if (!icw1_q[1]) begin
                                    state_q <= S_WAIT_ICW3;
                                end else if (icw1_q[0]) begin
                                    state_q <= S_WAIT_ICW4;
                                end else begin
                                    state_q <= S_READY;
                                    done_q  <= 1'b1;
                                end
                            end
                            S_WAIT_ICW3: begin
                                icw3_q <= data_cap_q;
                                if (icw1_q[0]) begin
                                    state_q <= S_WAIT_ICW4;
                                end else begin
                                    state_q <= S_READY;
                                    done_q  <= 1'b1;
                                end
                            end
                            S_WAIT_ICW4: begin
                                icw4_q  <= data_cap_q;
                                state_q <= S_READY;
                                done_q  <= 1'b1;
                            end
                            S_READY: ocw1_q <= data_cap_q;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ICW1      = icw1_q;
    assign ICW2      = icw2_q;
    assign ICW3      = icw3_q;
    assign ICW4      = icw4_q;
    assign OCW1      = ocw1_q;
    assign OCW2      = ocw2_q;
    assign OCW3      = ocw3_q;
    assign Data_out  = dout_q;
    assign Data_oe   = doe_q;
    assign init_done = done_q;
    assign icw1_stb  = icw1_stb_q;
    assign ocw2_stb  = ocw2_stb_q;

endmodule

// File: tb/tb_pic_cmd_ctrl.sv
// Directed bench for pic_cmd_ctrl: a write-vector table followed by
// hand sequences for latency, read-back, bus errors and mid-sequence reset.
module tb_pic_cmd_ctrl;

    localparam int DW = 8;
    localparam int S  = 2;

    logic          clk;
    logic          rst_n;
    logic          CS, WR, RD, A0;
    logic [DW-1:0] Data_in, IRR, ISR;
    logic [DW-1:0] Data_out;
    logic          Data_oe;
    logic [DW-1:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3;
    logic          init_done, icw1_stb, ocw2_stb;

    int checks = 0;
    int errors = 0;

    pic_cmd_ctrl #(.DATA_W(DW), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .CS(CS), .WR(WR), .RD(RD), .A0(A0),
        .Data_in(Data_in), .IRR(IRR), .ISR(ISR),
        .Data_out(Data_out), .Data_oe(Data_oe),
        .ICW1(ICW1), .ICW2(ICW2), .ICW3(ICW3), .ICW4(ICW4),
        .OCW1(OCW1), .OCW2(OCW2), .OCW3(OCW3),
        .init_done(init_done), .icw1_stb(icw1_stb), .ocw2_stb(ocw2_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a0;
        logic [7:0] d;
        logic [7:0] i1, i2, i3, i4, o1, o2, o3;
        logic       done;
    } vec_t;

    vec_t vt[10];

    function automatic logic [56:0] snap();
        return {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3, init_done};
    endfunction

    function automatic logic [56:0] pk(
        input logic [7:0] i1, i2, i3, i4, o1, o2, o3,
        input logic done);
        return {i1, i2, i3, i4, o1, o2, o3, done};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr_begin(input logic a0, input logic [7:0] d,
                            input logic cs, input logic rd);
        @(negedge clk);
        A0 = a0; Data_in = d; CS = cs; RD = rd;
        @(negedge clk);
        WR = 1'b0;
        repeat (3) @(negedge clk);
        WR = 1'b1;
    endtask

    task automatic wr_end();
        repeat (S + 3) @(negedge clk);
        CS = 1'b1; RD = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d);
        wr_begin(a0, d, 1'b0, 1'b1);
        wr_end();
    endtask

    task automatic do_read(input string nm, input logic a0,
                           input logic [7:0] exp);
        @(negedge clk);
        A0 = a0; CS = 1'b0;
        @(negedge clk);
        RD = 1'b0;
        repeat (S + 2) @(negedge clk);
        chk({nm, "_oe"}, 64'(Data_oe), 64'd1);
        chk(nm, 64'(Data_out), 64'(exp));
        RD = 1'b1;
        repeat (S + 2) @(negedge clk);
        chk({nm, "_oe_off"}, 64'(Data_oe), 64'd0);
        chk({nm, "_hold"}, 64'(Data_out), 64'(exp));
        CS = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{0, 8'hD5, 8'hD5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0};
        vt[1] = '{1, 8'hE8, 8'hD5, 8'hE8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0};
        vt[2] = '{1, 8'h0B, 8'hD5, 8'hE8, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 0};
        vt[3] = '{1, 8'h00, 8'hD5, 8'hE8, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 1};
        vt[4] = '{1, 8'h1F, 8'hD5, 8'hE8, 8'h0B, 8'h00, 8'h1F, 8'h00, 8'h00, 1};
        vt[5] = '{0, 8'hE0, 8'hD5, 8'hE8, 8'h0B, 8'h00, 8'h1F, 8'hE0, 8'h00, 1};
        vt[6] = '{0, 8'h68, 8'hD5, 8'hE8, 8'h0B, 8'h00, 8'h1F, 8'hE0, 8'h68, 1};
        vt[7] = '{0, 8'h16, 8'h16, 8'hE8, 8'h0B, 8'h00, 8'h00, 8'hE0, 8'h68, 0};
        vt[8] = '{1, 8'h40, 8'h16, 8'h40, 8'h0B, 8'h00, 8'h00, 8'hE0, 8'h68, 1};
        vt[9] = '{1, 8'h33, 8'h16, 8'h40, 8'h0B, 8'h00, 8'h33, 8'hE0, 8'h68, 1};

        rst_n = 1'b0; CS = 1'b1; WR = 1'b1; RD = 1'b1; A0 = 1'b0;
        Data_in = '0; IRR = 8'hA5; ISR = 8'h3C;
        repeat (2) @(negedge clk);
        chk("reset_regs", 64'(snap()), 64'd0);
        chk("reset_out", 64'({Data_out, Data_oe, icw1_stb, ocw2_stb}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_write(vt[i].a0, vt[i].d);
            chk($sformatf("vec%0d", i), 64'(snap()),
                64'(pk(vt[i].i1, vt[i].i2, vt[i].i3, vt[i].i4,
                       vt[i].o1, vt[i].o2, vt[i].o3, vt[i].done)));
        end

        // OCW2 commit latency and single-cycle strobe
        wr_begin(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (S) @(negedge clk);
        chk("ocw2_early", 64'(OCW2), 64'hE0);
        chk("ocw2_stb_early", 64'(ocw2_stb), 64'd0);
        @(negedge clk);
        chk("ocw2_land", 64'(OCW2), 64'h00);
        chk("ocw2_stb", 64'(ocw2_stb), 64'd1);
        @(negedge clk);
        chk("ocw2_stb_off", 64'(ocw2_stb), 64'd0);
        wr_end();

        // ICW1 commit latency and strobe
        wr_begin(1'b0, 8'h17, 1'b0, 1'b1);
        repeat (S) @(negedge clk);
        chk("icw1_early", 64'(ICW1), 64'h16);
        @(negedge clk);
        chk("icw1_land", 64'({ICW1, icw1_stb}), 64'({8'h17, 1'b1}));
        @(negedge clk);
        chk("icw1_stb_off", 64'(icw1_stb), 64'd0);
        wr_end();
        do_write(1'b1, 8'h40);
        do_write(1'b1, 8'h02);
        chk("icw4_path", 64'(snap()),
            64'(pk(8'h17, 8'h40, 8'h0B, 8'h02, 8'h00, 8'h00, 8'h68, 1)));
        do_write(1'b1, 8'h33);

        do_read("rd_irr", 1'b0, 8'hA5);
        do_write(1'b0, 8'h0B);
        do_read("rd_isr", 1'b0, 8'h3C);
        do_read("rd_ocw1", 1'b1, 8'h33);
        do_write(1'b0, 8'h08);
        chk("ocw3_rr0", 64'(OCW3), 64'h08);
        do_read("rd_keep", 1'b0, 8'h3C);

        // ICW1 issued while waiting for ICW3 restarts at ICW2
        do_write(1'b0, 8'h10);
        do_write(1'b1, 8'h11);
        do_write(1'b0, 8'h14);
        chk("restart_ocw1", 64'({OCW1, init_done}), 64'd0);
        do_write(1'b1, 8'h22);
        chk("restart_icw2", 64'(snap()),
            64'(pk(8'h14, 8'h22, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h08, 0)));

        wr_begin(1'b1, 8'h77, 1'b1, 1'b1);
        wr_end();
        chk("cs_high", 64'(snap()),
            64'(pk(8'h14, 8'h22, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h08, 0)));

        wr_begin(1'b1, 8'h66, 1'b0, 1'b0);
        wr_end();
        chk("bus_err", 64'(snap()),
            64'(pk(8'h14, 8'h22, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h08, 0)));

        do_write(1'b1, 8'h0C);
        chk("icw3_ready", 64'(snap()),
            64'(pk(8'h14, 8'h22, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h08, 1)));

        // reset while waiting for ICW4
        do_write(1'b0, 8'h11);
        do_write(1'b1, 8'hAA);
        do_write(1'b1, 8'hBB);
        chk("pre_reset", 64'(snap()),
            64'(pk(8'h11, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h08, 0)));
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_reset", 64'(snap()), 64'd0);
        do_write(1'b1, 8'hCC);
        chk("idle_a0_ignored", 64'(snap()), 64'd0);
        do_write(1'b0, 8'h13);
        chk("post_reset_icw1", 64'(snap()),
            64'(pk(8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
